// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data RAM arbiter: access mode codes,
// FSM state encoding and mode classification helpers.
package mem_arbiter_pkg;

  localparam logic [3:0] IO_NOP = 4'd0;
  localparam logic [3:0] IO_LW  = 4'd1;
  localparam logic [3:0] IO_LH  = 4'd2;
  localparam logic [3:0] IO_LHU = 4'd3;
  localparam logic [3:0] IO_LB  = 4'd4;
  localparam logic [3:0] IO_LBU = 4'd5;
  localparam logic [3:0] IO_SW  = 4'd6;
  localparam logic [3:0] IO_SH  = 4'd7;
  localparam logic [3:0] IO_SB  = 4'd8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_e;

  function automatic logic mode_is_load(input logic [3:0] mode);
    logic res;
    case (mode)
      IO_LW, IO_LH, IO_LHU, IO_LB, IO_LBU: res = 1'b1;
      default:                             res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic mode_is_store(input logic [3:0] mode);
    logic res;
    case (mode)
      IO_SW, IO_SH, IO_SB: res = 1'b1;
      default:             res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic mode_is_known(input logic [3:0] mode);
    return mode_is_load(mode) | mode_is_store(mode);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch and data ports, the arbiter and the RAM.
// The arbiter uses the slave view; the CPU-side requesters plus RAM use the master view.
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic [3:0]  d_mode;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [3:0]  ram_mode;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_mode, d_addr, d_wdata, ram_rdata,
    output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata, d_err,
           ram_mode, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_mode, d_addr, d_wdata, ram_rdata,
    input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata, d_err,
           ram_mode, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_arbiter_align_check.sv
// Flags data accesses whose address is not a multiple of the access size.
// Byte accesses and unknown modes are always considered aligned.
module mem_align_check
  import mem_arbiter_pkg::*;
(
  input  logic [3:0] mode,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  logic misaligned_s;

  // Size-dependent alignment rule
  always_comb begin
    misaligned_s = 1'b0;
    case (mode)
      IO_LW, IO_SW:         misaligned_s = (addr_lo != 2'b00);
      IO_LH, IO_LHU, IO_SH: misaligned_s = addr_lo[0];
      default:              misaligned_s = 1'b0;
    endcase
  end

  assign misaligned = misaligned_s;

endmodule

// File: rtl/mem_arbiter.sv
// Merges the fetch and data ports onto one single-port RAM: data has priority,
// fetch is guaranteed a win after STARVE_MAX consecutive losses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned ADDR_W     = 23
)
(
  input logic            clk,
  input logic            rst_n,
  mem_arbiter_if.slave   bus
);

  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [31:0] ADDR_MASK  = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << ADDR_W) - 32'd1);

  arb_state_e  state_r, state_nxt_s;
  arb_owner_e  owner_r, owner_nxt_s;
  logic [3:0]  starve_cnt_r, starve_cnt_nxt_s;
  logic [3:0]  ram_mode_r, ram_mode_nxt_s;
  logic [31:0] ram_addr_r, ram_addr_nxt_s;
  logic [31:0] ram_wdata_r, ram_wdata_nxt_s;
  logic        if_rvalid_r, if_rvalid_nxt_s;
  logic [31:0] if_rdata_r, if_rdata_nxt_s;
  logic        d_rvalid_r, d_rvalid_nxt_s;
  logic        d_err_r, d_err_nxt_s;
  logic [31:0] d_rdata_r, d_rdata_nxt_s;

  logic        can_accept_s;
  logic        fetch_win_s;
  logic        data_win_s;
  logic        misaligned_s;
  logic [3:0]  d_mode_eff_s;

  mem_align_check u_align_check (
    .mode       (bus.d_mode),
    .addr_lo    (bus.d_addr[1:0]),
    .misaligned (misaligned_s)
  );

  // Arbitration: data wins unless fetch has lost STARVE_MAX times in a row
  always_comb begin
    can_accept_s = (state_r == ARB_IDLE) || (state_r == ARB_RESP);
    fetch_win_s  = bus.if_req && (!bus.d_req || (starve_cnt_r == STARVE_LIM));
    data_win_s   = bus.d_req && !fetch_win_s;
    d_mode_eff_s = mode_is_known(bus.d_mode) ? bus.d_mode : IO_NOP;
  end

  assign bus.if_ready = can_accept_s & fetch_win_s;
  assign bus.d_ready  = can_accept_s & data_win_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: misaligned data skips the RAM cycle
  always_comb begin
    state_nxt_s = ARB_IDLE;
    case (state_r)
      ARB_IDLE, ARB_RESP: begin
        if (fetch_win_s) begin
          state_nxt_s = ARB_ACCESS;
        end else if (data_win_s) begin
          state_nxt_s = misaligned_s ? ARB_RESP : ARB_ACCESS;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_ACCESS: state_nxt_s = ARB_RESP;
      default:    state_nxt_s = ARB_IDLE;
    endcase
  end

  // FSM outputs: next values for the registered RAM drive and response regs
  always_comb begin
    owner_nxt_s      = owner_r;
    starve_cnt_nxt_s = starve_cnt_r;
    ram_mode_nxt_s   = IO_NOP;
    ram_addr_nxt_s   = ram_addr_r;
    ram_wdata_nxt_s  = ram_wdata_r;
    if_rvalid_nxt_s  = 1'b0;
    if_rdata_nxt_s   = if_rdata_r;
    d_rvalid_nxt_s   = 1'b0;
    d_err_nxt_s      = 1'b0;
    d_rdata_nxt_s    = d_rdata_r;
    case (state_r)
      ARB_IDLE, ARB_RESP: begin
        if (fetch_win_s) begin
          owner_nxt_s      = OWN_FETCH;
          starve_cnt_nxt_s = 4'd0;
          ram_mode_nxt_s   = IO_LW;
          ram_addr_nxt_s   = bus.if_addr & ADDR_MASK;
        end else if (data_win_s) begin
          owner_nxt_s = OWN_DATA;
          if (bus.if_req && (starve_cnt_r < STARVE_LIM)) begin
            starve_cnt_nxt_s = starve_cnt_r + 4'd1;
          end else begin
            starve_cnt_nxt_s = starve_cnt_r;
          end
          if (misaligned_s) begin
            d_rvalid_nxt_s = 1'b1;
            d_err_nxt_s    = 1'b1;
            d_rdata_nxt_s  = 32'd0;
          end else begin
            ram_mode_nxt_s  = d_mode_eff_s;
            ram_addr_nxt_s  = bus.d_addr & ADDR_MASK;
            ram_wdata_nxt_s = bus.d_wdata;
          end
        end else begin
          owner_nxt_s = owner_r;
        end
      end
      ARB_ACCESS: begin
        // RAM data is sampled at the same edge that commits a store
        if (owner_r == OWN_FETCH) begin
          if_rvalid_nxt_s = 1'b1;
          if_rdata_nxt_s  = bus.ram_rdata;
        end else begin
          d_rvalid_nxt_s = 1'b1;
          d_rdata_nxt_s  = mode_is_load(ram_mode_r) ? bus.ram_rdata : 32'd0;
        end
      end
      default: begin
        owner_nxt_s = owner_r;
      end
    endcase
  end

  // Datapath and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r      <= OWN_FETCH;
      starve_cnt_r <= 4'd0;
      ram_mode_r   <= IO_NOP;
      ram_addr_r   <= 32'd0;
      ram_wdata_r  <= 32'd0;
      if_rvalid_r  <= 1'b0;
      if_rdata_r   <= 32'd0;
      d_rvalid_r   <= 1'b0;
      d_err_r      <= 1'b0;
      d_rdata_r    <= 32'd0;
    end else begin
      owner_r      <= owner_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
      ram_mode_r   <= ram_mode_nxt_s;
      ram_addr_r   <= ram_addr_nxt_s;
      ram_wdata_r  <= ram_wdata_nxt_s;
      if_rvalid_r  <= if_rvalid_nxt_s;
      if_rdata_r   <= if_rdata_nxt_s;
      d_rvalid_r   <= d_rvalid_nxt_s;
      d_err_r      <= d_err_nxt_s;
      d_rdata_r    <= d_rdata_nxt_s;
    end
  end

  assign bus.ram_mode  = ram_mode_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wdata = ram_wdata_r;
  assign bus.if_rvalid = if_rvalid_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_rvalid  = d_rvalid_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.d_err     = d_err_r;

endmodule
